// File: rtl/pwm_multi_ch.sv
// N-channel PWM generator with double-buffered period/duty behind a local-bus register port.
// Define PWM_MULTI_CH_IRQ_EN to build the period-end STATUS/IRQ_MASK/IRQ_O logic.

module pwm_multi_ch #(
  parameter int         NUM_CH       = 2,
  parameter int         CNT_W        = 12,
  parameter int         ADDR_W       = 16,
  parameter int         DATA_W       = 32,
  parameter int         DEFAULT_PER  = 1000,
  parameter int         DEFAULT_DUTY = 0,
  parameter logic [1:0] DEFAULT_CTRL = 2'b00
) (
  input  logic              S_AXI_ACLK,
  input  logic              S_AXI_ARESETN,
  input  logic              LB_WREQ,
  input  logic [ADDR_W-1:0] LB_WADDR,
  input  logic [DATA_W-1:0] LB_WDATA,
  input  logic              LB_RREQ,
  input  logic [ADDR_W-1:0] LB_RADDR,
  output logic [DATA_W-1:0] LB_RDATA,
  output logic              LB_RFINISH,
  output logic [NUM_CH-1:0] PWM_O,
  output logic [NUM_CH-1:0] PWM_EN_O,
  output logic              IRQ_O
);

  localparam logic [CNT_W-1:0] DEF_PER  = CNT_W'(DEFAULT_PER);
  localparam logic [CNT_W-1:0] DEF_DUTY = CNT_W'(DEFAULT_DUTY);
  localparam logic [CNT_W-1:0] MIN_PER  = CNT_W'(2);

  logic [1:0]       rstSync_q;
  logic             rstN;

  logic [1:0]       ctrl_q    [NUM_CH];
  logic [1:0]       ctrl_d    [NUM_CH];
  logic [CNT_W-1:0] perSh_q   [NUM_CH];
  logic [CNT_W-1:0] perSh_d   [NUM_CH];
  logic [CNT_W-1:0] dutySh_q  [NUM_CH];
  logic [CNT_W-1:0] dutySh_d  [NUM_CH];
  logic [CNT_W-1:0] perAct_q  [NUM_CH];
  logic [CNT_W-1:0] perAct_d  [NUM_CH];
  logic [CNT_W-1:0] dutyAct_q [NUM_CH];
  logic [CNT_W-1:0] dutyAct_d [NUM_CH];
  logic [CNT_W-1:0] cnt_q     [NUM_CH];
  logic [CNT_W-1:0] cnt_d     [NUM_CH];
  logic [CNT_W-1:0] perEff    [NUM_CH];

  logic [NUM_CH-1:0] pwm_q;
  logic [NUM_CH-1:0] pwm_d;
  logic [NUM_CH-1:0] wrap;
  logic [NUM_CH-1:0] wrCh;
  logic [NUM_CH-1:0] rdCh;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;
  logic              rfinish_q;
  logic              unused_wdata;

  assign unused_wdata = ^LB_WDATA;

  // Assert asynchronously, release two clocks after ARESETN rises.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) rstSync_q <= 2'b00;
    else                rstSync_q <= {rstSync_q[0], 1'b1};
  end

  assign rstN = rstSync_q[1];

  always_comb begin
    wrCh = '0;
    rdCh = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wrCh[i] = LB_WREQ && (LB_WADDR[1:0] == 2'b00) &&
                (LB_WADDR[ADDR_W-1:4] == (ADDR_W-4)'(i));
      rdCh[i] = (LB_RADDR[1:0] == 2'b00) &&
                (LB_RADDR[ADDR_W-1:4] == (ADDR_W-4)'(i));
    end
  end

  // Period length is clamped to 2 so a channel can never stall on a zero/one period.
  always_comb begin
    wrap = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      perEff[i] = (perAct_q[i] < MIN_PER) ? MIN_PER : perAct_q[i];
      wrap[i]   = ctrl_q[i][0] && (cnt_q[i] >= perEff[i] - 1'b1);
    end
  end

  always_comb begin
    pwm_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ctrl_d[i]    = ctrl_q[i];
      perSh_d[i]   = perSh_q[i];
      dutySh_d[i]  = dutySh_q[i];
      perAct_d[i]  = perAct_q[i];
      dutyAct_d[i] = dutyAct_q[i];
      cnt_d[i]     = cnt_q[i] + 1'b1;

      // Active values only change at a wrap or while idle, so a period is never cut short.
      if (!ctrl_q[i][0] || wrap[i]) begin
        cnt_d[i]     = '0;
        perAct_d[i]  = perSh_q[i];
        dutyAct_d[i] = dutySh_q[i];
      end

      pwm_d[i] = ctrl_q[i][0] ? ((cnt_q[i] < dutyAct_q[i]) ^ ctrl_q[i][1]) : ctrl_q[i][1];

      if (wrCh[i]) begin
        case (LB_WADDR[3:2])
          2'd0:    ctrl_d[i]   = LB_WDATA[1:0];
          2'd1:    perSh_d[i]  = LB_WDATA[CNT_W-1:0];
          2'd2:    dutySh_d[i] = LB_WDATA[CNT_W-1:0];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < NUM_CH; i++) begin
        ctrl_q[i]    <= DEFAULT_CTRL;
        perSh_q[i]   <= DEF_PER;
        dutySh_q[i]  <= DEF_DUTY;
        perAct_q[i]  <= DEF_PER;
        dutyAct_q[i] <= DEF_DUTY;
        cnt_q[i]     <= '0;
      end
      pwm_q <= {NUM_CH{DEFAULT_CTRL[1]}};
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        ctrl_q[i]    <= ctrl_d[i];
        perSh_q[i]   <= perSh_d[i];
        dutySh_q[i]  <= dutySh_d[i];
        perAct_q[i]  <= perAct_d[i];
        dutyAct_q[i] <= dutyAct_d[i];
        cnt_q[i]     <= cnt_d[i];
      end
      pwm_q <= pwm_d;
    end
  end

`ifdef PWM_MULTI_CH_IRQ_EN
  localparam logic [ADDR_W-1:0] ADDR_STATUS = ADDR_W'(16'h0F00);
  localparam logic [ADDR_W-1:0] ADDR_MASK   = ADDR_W'(16'h0F04);

  logic [NUM_CH-1:0] status_q;
  logic [NUM_CH-1:0] status_d;
  logic [NUM_CH-1:0] mask_q;
  logic [NUM_CH-1:0] mask_d;
  logic              irq_q;

  // Clear is applied first so a wrap in the same cycle keeps its STATUS bit.
  always_comb begin
    status_d = status_q;
    mask_d   = mask_q;
    if (LB_WREQ && (LB_WADDR == ADDR_STATUS)) status_d = status_q & ~LB_WDATA[NUM_CH-1:0];
    if (LB_WREQ && (LB_WADDR == ADDR_MASK))   mask_d   = LB_WDATA[NUM_CH-1:0];
    status_d = status_d | wrap;
  end

  always_ff @(posedge S_AXI_ACLK or negedge rstN) begin
    if (!rstN) begin
      status_q <= '0;
      mask_q   <= '0;
      irq_q    <= 1'b0;
    end else begin
      status_q <= status_d;
      mask_q   <= mask_d;
      irq_q    <= |(status_q & mask_q);
    end
  end

  assign IRQ_O = irq_q;
`else
  assign IRQ_O = 1'b0;
`endif

  always_comb begin
    rdata_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rdCh[i]) begin
        case (LB_RADDR[3:2])
          2'd0:    rdata_d = DATA_W'(ctrl_q[i]);
          2'd1:    rdata_d = DATA_W'(perSh_q[i]);
          2'd2:    rdata_d = DATA_W'(dutySh_q[i]);
          default: rdata_d = DATA_W'(cnt_q[i]);
        endcase
      end
    end
`ifdef PWM_MULTI_CH_IRQ_EN
    if (LB_RADDR == ADDR_STATUS) rdata_d = DATA_W'(status_q);
    if (LB_RADDR == ADDR_MASK)   rdata_d = DATA_W'(mask_q);
`endif
  end

  always_ff @(posedge S_AXI_ACLK or negedge rstN) begin
    if (!rstN) begin
      rdata_q   <= '0;
      rfinish_q <= 1'b0;
    end else begin
      rdata_q   <= LB_RREQ ? rdata_d : '0;
      rfinish_q <= LB_RREQ;
    end
  end

  always_comb begin
    PWM_EN_O = '0;
    for (int i = 0; i < NUM_CH; i++) PWM_EN_O[i] = ctrl_q[i][0];
  end

  assign PWM_O      = pwm_q;
  assign LB_RDATA   = rdata_q;
  assign LB_RFINISH = rfinish_q;

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Randomised bench for pwm_multi_ch: each channel's waveform is modelled period by period
// as a queue of expected output bits built from the register values in force at period start.

module tb_pwm_multi_ch;

  localparam int NCH = 2;
  localparam int CW  = 12;
  localparam int AW  = 16;
  localparam int DW  = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          LB_WREQ = 1'b0;
  logic [AW-1:0] LB_WADDR = '0;
  logic [DW-1:0] LB_WDATA = '0;
  logic          LB_RREQ = 1'b0;
  logic [AW-1:0] LB_RADDR = '0;
  logic [DW-1:0] LB_RDATA;
  logic          LB_RFINISH;
  logic [NCH-1:0] PWM_O;
  logic [NCH-1:0] PWM_EN_O;
  logic          IRQ_O;

  int checks = 0;
  int errors = 0;

  bit mEn   [NCH];
  bit mPol  [NCH];
  int mPerSh  [NCH];
  int mDutySh [NCH];
  int mPlen   [NCH];
  bit rawQ  [NCH][$];
  int mStatus;
  int mMask;

  pwm_multi_ch #(
    .NUM_CH(NCH), .CNT_W(CW), .ADDR_W(AW), .DATA_W(DW),
    .DEFAULT_PER(1000), .DEFAULT_DUTY(0), .DEFAULT_CTRL(2'b00)
  ) dut (
    .S_AXI_ACLK(clk),
    .S_AXI_ARESETN(rst_n),
    .LB_WREQ(LB_WREQ),
    .LB_WADDR(LB_WADDR),
    .LB_WDATA(LB_WDATA),
    .LB_RREQ(LB_RREQ),
    .LB_RADDR(LB_RADDR),
    .LB_RDATA(LB_RDATA),
    .LB_RFINISH(LB_RFINISH),
    .PWM_O(PWM_O),
    .PWM_EN_O(PWM_EN_O),
    .IRQ_O(IRQ_O)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void modelReset();
    for (int c = 0; c < NCH; c++) begin
      mEn[c] = 1'b0; mPol[c] = 1'b0;
      mPerSh[c] = 1000; mDutySh[c] = 0;
      mPlen[c] = 0; rawQ[c].delete();
    end
    mStatus = 0;
    mMask   = 0;
  endfunction

  // One whole period: 'duty' high samples followed by low ones, length max(per,2).
  function automatic void startPeriod(int c, int per, int duty);
    int p;
    p = (per < 2) ? 2 : per;
    rawQ[c].delete();
    for (int j = 0; j < p; j++) rawQ[c].push_back(j < duty);
    mPlen[c] = p;
  endfunction

  function automatic logic [31:0] modelRead(logic [AW-1:0] a);
    int c;
    c = int'(a >> 4);
    if (a[1:0] == 2'b00 && c < NCH) begin
      case (a[3:2])
        2'd0:    return 32'({mPol[c], mEn[c]});
        2'd1:    return 32'(mPerSh[c]);
        2'd2:    return 32'(mDutySh[c]);
        default: return 32'(mPlen[c] - rawQ[c].size());
      endcase
    end
`ifdef PWM_MULTI_CH_IRQ_EN
    if (a == 16'h0F00) return 32'(mStatus);
    if (a == 16'h0F04) return 32'(mMask);
`endif
    return 32'h0;
  endfunction

  task automatic applyStimulus(input bit wreq, input logic [AW-1:0] waddr, input logic [DW-1:0] wdata,
                               input bit rreq, input logic [AW-1:0] raddr);
    logic [NCH-1:0] expPwm;
    logic [NCH-1:0] expEn;
    logic [31:0]    expRd;
    bit             expIrq;
    bit             preEn   [NCH];
    int             capPer  [NCH];
    int             capDuty [NCH];
    int             wrapBits;
    int             c;
    LB_WREQ = wreq; LB_WADDR = waddr; LB_WDATA = wdata;
    LB_RREQ = rreq; LB_RADDR = raddr;
    for (int k = 0; k < NCH; k++) begin
      preEn[k]   = mEn[k];
      capPer[k]  = mPerSh[k];
      capDuty[k] = mDutySh[k];
      if (mEn[k]) expPwm[k] = ((rawQ[k].size() > 0) ? rawQ[k][0] : 1'b0) ^ mPol[k];
      else        expPwm[k] = mPol[k];
    end
    expRd  = modelRead(raddr);
    expIrq = (mStatus & mMask) != 0;
    @(posedge clk);
    #1;
    wrapBits = 0;
    for (int k = 0; k < NCH; k++) begin
      if (preEn[k]) begin
        void'(rawQ[k].pop_front());
        if (rawQ[k].size() == 0) begin
          wrapBits |= (1 << k);
          startPeriod(k, capPer[k], capDuty[k]);
        end
      end
    end
    if (wreq) begin
      c = int'(waddr >> 4);
      if (waddr[1:0] == 2'b00 && c < NCH) begin
        case (waddr[3:2])
          2'd0: begin mEn[c] = wdata[0]; mPol[c] = wdata[1]; end
          2'd1: mPerSh[c]  = int'(wdata & 32'hFFF);
          2'd2: mDutySh[c] = int'(wdata & 32'hFFF);
          default: ;
        endcase
      end
`ifdef PWM_MULTI_CH_IRQ_EN
      if (waddr == 16'h0F00) mStatus &= ~int'(wdata & ((1 << NCH) - 1));
      if (waddr == 16'h0F04) mMask    = int'(wdata & ((1 << NCH) - 1));
`endif
    end
`ifdef PWM_MULTI_CH_IRQ_EN
    mStatus |= wrapBits;
`endif
    for (int k = 0; k < NCH; k++) begin
      if (!preEn[k]) begin
        if (mEn[k]) startPeriod(k, capPer[k], capDuty[k]);
        else begin rawQ[k].delete(); mPlen[k] = 0; end
      end
      expEn[k] = mEn[k];
    end
    checkOutput("pwm_o", 32'(PWM_O), 32'(expPwm));
    checkOutput("pwm_en_o", 32'(PWM_EN_O), 32'(expEn));
    checkOutput("rfinish", 32'(LB_RFINISH), 32'(rreq));
    if (rreq) checkOutput("rdata", LB_RDATA, expRd);
    checkOutput("irq_o", 32'(IRQ_O), 32'(expIrq));
    LB_WREQ = 1'b0;
    LB_RREQ = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    applyStimulus(1'b1, a, d, 1'b0, '0);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    applyStimulus(1'b0, '0, '0, 1'b1, a);
  endtask

  task automatic countHigh(input int b, input int n, output int ones);
    ones = 0;
    for (int k = 0; k < n; k++) begin
      idle(1);
      ones += int'(PWM_O[b]);
    end
  endtask

  function automatic logic [AW-1:0] randomAddr();
    int c;
    c = $urandom_range(0, NCH - 1);
    case ($urandom_range(0, 7))
      0, 1:    return AW'(c * 16);
      2:       return AW'(c * 16 + 4);
      3:       return AW'(c * 16 + 8);
      4:       return AW'(c * 16 + 12);
      5:       return 16'h0F00;
      6:       return 16'h0F04;
      default: return 16'h0200;
    endcase
  endfunction

  task automatic randomWrite();
    int c;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    c = $urandom_range(0, NCH - 1);
    case ($urandom_range(0, 9))
      0, 1, 2: begin a = AW'(c * 16);     d = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 3)); end
      3, 4, 5: begin a = AW'(c * 16 + 4); d = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 20)); end
      6, 7:    begin a = AW'(c * 16 + 8); d = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 22)); end
      8:       begin a = AW'(c * 16 + 12); d = $urandom; end
      default: begin
        case ($urandom_range(0, 3))
          0:       a = 16'h0F00;
          1:       a = 16'h0F04;
          2:       a = 16'h0200;
          default: a = AW'(c * 16 + 1);
        endcase
        d = $urandom;
      end
    endcase
    wr(a, d);
  endtask

  initial begin
    int ones;
    bit hit;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_pwm_o", 32'(PWM_O), 32'h0);
    checkOutput("rst_pwm_en_o", 32'(PWM_EN_O), 32'h0);
    checkOutput("rst_rfinish", 32'(LB_RFINISH), 32'h0);
    checkOutput("rst_rdata", LB_RDATA, 32'h0);
    checkOutput("rst_irq", 32'(IRQ_O), 32'h0);
    rst_n = 1'b1;
    idle(4);
    rd(16'h0004);
    checkOutput("rst_ch0_per", LB_RDATA, 32'd1000);

    wr(16'h0004, 32'd10);
    wr(16'h0008, 32'd3);
    wr(16'h0000, 32'd1);
    idle(3);
    countHigh(0, 10, ones);
    checkOutput("ch0_high_in_10", 32'(ones), 32'd3);

    hit = 1'b0;
    for (int t = 0; t < 30 && !hit; t++) begin
      rd(16'h000C);
      if (LB_RDATA == 32'd3) hit = 1'b1;
    end
    checkOutput("ch0_cnt_seen", 32'(hit), 32'h1);
    wr(16'h0004, 32'd4);
    wr(16'h0008, 32'd2);
    idle(20);
    countHigh(0, 8, ones);
    checkOutput("ch0_high_in_8_after_shrink", 32'(ones), 32'd4);

    wr(16'h0014, 32'd8);
    wr(16'h0018, 32'd8);
    wr(16'h0010, 32'd3);
    idle(2);
    countHigh(1, 16, ones);
    checkOutput("ch1_duty_full_inverted", 32'(ones), 32'd0);
    rd(16'h0014);
    checkOutput("rd_ch1_per", LB_RDATA, 32'd8);
    rd(16'h0200);
    checkOutput("rd_unmapped", LB_RDATA, 32'd0);
    wr(16'h0018, 32'd0);
    idle(10);
    countHigh(1, 8, ones);
    checkOutput("ch1_duty_zero_inverted", 32'(ones), 32'd8);
    wr(16'h0014, 32'd1);
    wr(16'h0018, 32'd1);
    idle(12);
    countHigh(1, 4, ones);
    checkOutput("ch1_per1_clamped", 32'(ones), 32'd2);

`ifdef PWM_MULTI_CH_IRQ_EN
    wr(16'h0004, 32'd6);
    wr(16'h0F04, 32'd1);
    wr(16'h0F00, 32'd3);
    hit = 1'b0;
    for (int t = 0; t < 20 && !hit; t++) begin
      idle(1);
      if (IRQ_O) hit = 1'b1;
    end
    checkOutput("irq_rise", 32'(hit), 32'h1);
    wr(16'h0F00, 32'd1);
    idle(14);
    rd(16'h0F04);
    checkOutput("irq_mask_rd", LB_RDATA, 32'd1);
`else
    wr(16'h0F04, 32'd1);
    rd(16'h0F04);
    checkOutput("mask_absent", LB_RDATA, 32'd0);
    rd(16'h0F00);
    checkOutput("status_absent", LB_RDATA, 32'd0);
    checkOutput("irq_tied", 32'(IRQ_O), 32'd0);
`endif

    rd(16'h0010);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_pwm_o", 32'(PWM_O), 32'h0);
    checkOutput("midrst_rfinish", 32'(LB_RFINISH), 32'h0);
    checkOutput("midrst_pwm_en_o", 32'(PWM_EN_O), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    modelReset();
    idle(4);
    rd(16'h0004);
    checkOutput("midrst_ch0_per", LB_RDATA, 32'd1000);

    for (int c = 0; c < 1500; c++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 3)      randomWrite();
      else if (sel < 5) rd(randomAddr());
      else              idle(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
